// File: rtl/fusion_pkg.sv
// Shared definitions for the fusion MAC: lane-fusion mode encodings and default widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fusion_pkg;

    // Per-beat lane fusion; the unused encoding 2'b11 behaves like MODE_1X
    typedef enum logic [1:0] {
        MODE_1X = 2'b00,
        MODE_2X = 2'b01,
        MODE_4X = 2'b10
    } mode_e;

    localparam int DEF_W     = 8;
    localparam int DEF_ACC_W = 24;

endpackage

// File: rtl/fusion_lane_mult.sv
// One lane multiplier: L x L operands, each independently signed or unsigned, 2L-bit product.
// Latency: combinational.
// Backpressure: none; the caller registers around it.
module fusion_lane_mult #(
    parameter int L = 4
) (
    input  logic [L-1:0]   a,
    input  logic [L-1:0]   b,
    input  logic           a_signed,
    input  logic           b_signed,
    output logic [2*L-1:0] prod
);

    // One guard bit per operand lets a single signed multiply cover all four sign mixes
    logic signed [L:0]     a_ext;
    logic signed [L:0]     b_ext;
    logic signed [2*L+1:0] full;
    logic                  unused_hi;

    assign a_ext = $signed({a_signed & a[L-1], a});
    assign b_ext = $signed({b_signed & b[L-1], b});
    assign full  = a_ext * b_ext;

    // Any mix of L-bit operands fits in 2L bits, so the top two bits are redundant
    assign prod      = full[2*L-1:0];
    assign unused_hi = ^full[2*L+1:2*L];

endmodule

// File: rtl/fusion_mac.sv
// Mixed-precision fused MAC: 1/2/4 lanes per beat, saturating accumulation over a vector.
// Latency: last beat accepted at edge k -> result valid after edge k+2.
// Backpressure: a pending unread result freezes the whole pipeline and drops in_ready.
module fusion_mac
    import fusion_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic [W-1:0]     weight,
    input  logic             s_in,
    input  logic             s_weight,
    input  logic [1:0]       mode,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_psum,
    output logic             out_sat
);

    localparam int L1 = W;
    localparam int L2 = W / 2;
    localparam int L4 = W / 4;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic stall;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    // ---------------- stage 1: captured operands ----------------
    logic         s1_vld;
    logic [W-1:0] s1_dat;
    logic [W-1:0] s1_wgt;
    logic         s1_s_in;
    logic         s1_s_wgt;
    logic [1:0]   s1_mode;
    logic         s1_last;

    // Capture each offered beat together with its own mode and sign flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld   <= 1'b0;
            s1_dat   <= '0;
            s1_wgt   <= '0;
            s1_s_in  <= 1'b0;
            s1_s_wgt <= 1'b0;
            s1_mode  <= 2'b00;
            s1_last  <= 1'b0;
        end else if (!stall) begin
            s1_vld   <= in_valid;
            s1_dat   <= in_data;
            s1_wgt   <= weight;
            s1_s_in  <= s_in;
            s1_s_wgt <= s_weight;
            s1_mode  <= mode;
            s1_last  <= in_last;
        end
    end

    // ---------------- lane products ----------------
    // A product is signed whenever either operand is signed
    logic prod_signed;
    assign prod_signed = s1_s_in | s1_s_wgt;

    logic [2*L1-1:0]  p1;
    logic [ACC_W-1:0] e1;

    fusion_lane_mult #(.L(L1)) u_mult_1x (
        .a        (s1_dat),
        .b        (s1_wgt),
        .a_signed (s1_s_in),
        .b_signed (s1_s_wgt),
        .prod     (p1)
    );
    assign e1 = {{(ACC_W-2*L1){prod_signed & p1[2*L1-1]}}, p1};

    logic [2*L2-1:0]  p2 [2];
    logic [ACC_W-1:0] e2 [2];

    for (genvar g = 0; g < 2; g++) begin : g_2x
        fusion_lane_mult #(.L(L2)) u_mult (
            .a        (s1_dat[g*L2 +: L2]),
            .b        (s1_wgt[g*L2 +: L2]),
            .a_signed (s1_s_in),
            .b_signed (s1_s_wgt),
            .prod     (p2[g])
        );
        assign e2[g] = {{(ACC_W-2*L2){prod_signed & p2[g][2*L2-1]}}, p2[g]};
    end

    logic [2*L4-1:0]  p4 [4];
    logic [ACC_W-1:0] e4 [4];

    for (genvar g = 0; g < 4; g++) begin : g_4x
        fusion_lane_mult #(.L(L4)) u_mult (
            .a        (s1_dat[g*L4 +: L4]),
            .b        (s1_wgt[g*L4 +: L4]),
            .a_signed (s1_s_in),
            .b_signed (s1_s_wgt),
            .prod     (p4[g])
        );
        assign e4[g] = {{(ACC_W-2*L4){prod_signed & p4[g][2*L4-1]}}, p4[g]};
    end

    // Beat sum: add the lanes selected by this beat's mode (exact, ACC_W >= 2W+2)
    logic [ACC_W-1:0] beat_sum;

    always_comb begin
        beat_sum = e1;
        case (s1_mode)
            MODE_2X: beat_sum = e2[0] + e2[1];
            MODE_4X: beat_sum = e4[0] + e4[1] + e4[2] + e4[3];
            default: beat_sum = e1;
        endcase
    end

    // ---------------- stage 2: registered beat sum ----------------
    logic             s2_vld;
    logic             s2_last;
    logic [ACC_W-1:0] s2_sum;

    // Register the beat sum with its valid and end-of-vector marker
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_vld  <= 1'b0;
            s2_last <= 1'b0;
            s2_sum  <= '0;
        end else if (!stall) begin
            s2_vld  <= s1_vld;
            s2_last <= s1_last;
            s2_sum  <= beat_sum;
        end
    end

    // ---------------- stage 3: saturating accumulator ----------------
    logic             in_vec;     // 1 once a vector has started and not yet finished
    logic [ACC_W-1:0] acc;
    logic             sat_flag;

    logic [ACC_W-1:0] acc_base;
    logic             sat_base;
    logic [ACC_W:0]   acc_wide;
    logic             acc_ovf;
    logic [ACC_W-1:0] acc_next;
    logic             sat_next;

    // Add with one extra bit; a differing top pair means the true sum left ACC_W range
    always_comb begin
        acc_base = in_vec ? acc : '0;
        sat_base = in_vec & sat_flag;
        acc_wide = {acc_base[ACC_W-1], acc_base} + {s2_sum[ACC_W-1], s2_sum};
        acc_ovf  = acc_wide[ACC_W] ^ acc_wide[ACC_W-1];
        acc_next = acc_wide[ACC_W-1:0];
        if (acc_ovf) begin
            acc_next = acc_wide[ACC_W] ? ACC_MIN : ACC_MAX;
        end
        sat_next = sat_base | acc_ovf;
    end

    // Accumulate beats; the last beat publishes the result and rearms for a new vector
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_vec    <= 1'b0;
            acc       <= '0;
            sat_flag  <= 1'b0;
            out_valid <= 1'b0;
            out_psum  <= '0;
            out_sat   <= 1'b0;
        end else if (!stall) begin
            out_valid <= s2_vld && s2_last;
            if (s2_vld) begin
                if (s2_last) begin
                    out_psum <= acc_next;
                    out_sat  <= sat_next;
                    in_vec   <= 1'b0;
                    acc      <= '0;
                    sat_flag <= 1'b0;
                end else begin
                    acc      <= acc_next;
                    sat_flag <= sat_next;
                    in_vec   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fusion_mac.sv
module tb_fusion_mac;

    localparam longint MAXV = (longint'(1) << 23) - 1;
    localparam longint MINV = -(longint'(1) << 23);

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [7:0]  weight;
    logic        s_in;
    logic        s_weight;
    logic [1:0]  mode;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_psum;
    logic        out_sat;

    int total = 0;
    int bad   = 0;

    logic [23:0] got_psum [$];
    logic        got_sat  [$];
    logic [23:0] exp_psum [$];
    logic        exp_sat  [$];

    longint      m_acc;
    bit          m_sat;
    bit          m_in_vec;
    logic [23:0] last_psum;
    logic        last_sat;

    fusion_mac #(.W(8), .ACC_W(24)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .weight    (weight),
        .s_in      (s_in),
        .s_weight  (s_weight),
        .mode      (mode),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_psum  (out_psum),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // Record every result handshake that the next rising edge will complete
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            got_psum.push_back(out_psum);
            got_sat.push_back(out_sat);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: dot product of the beat's lanes in plain integer arithmetic
    function automatic longint lane_sum(input logic [7:0] d, input logic [7:0] w,
                                        input logic [1:0] m, input bit si, input bit sw);
        int     n;
        int     l;
        longint s;
        longint a;
        longint b;
        n = (m == 2'b01) ? 2 : (m == 2'b10) ? 4 : 1;
        l = 8 / n;
        s = 0;
        for (int i = 0; i < n; i++) begin
            a = (longint'(d) >> (i * l)) & ((longint'(1) << l) - 1);
            b = (longint'(w) >> (i * l)) & ((longint'(1) << l) - 1);
            if (si && a >= (longint'(1) << (l - 1))) a -= (longint'(1) << l);
            if (sw && b >= (longint'(1) << (l - 1))) b -= (longint'(1) << l);
            s += a * b;
        end
        return s;
    endfunction

    task automatic model_beat(input logic [7:0] d, input logic [7:0] w, input logic [1:0] m,
                              input bit si, input bit sw, input bit last);
        if (!m_in_vec) begin
            m_acc = 0;
            m_sat = 0;
        end
        m_acc += lane_sum(d, w, m, si, sw);
        if (m_acc > MAXV) begin
            m_acc = MAXV;
            m_sat = 1;
        end else if (m_acc < MINV) begin
            m_acc = MINV;
            m_sat = 1;
        end
        if (last) begin
            exp_psum.push_back(m_acc[23:0]);
            exp_sat.push_back(m_sat);
        end
        m_in_vec = !last;
    endtask

    // Offer one beat and hold it until accepted; called at posedge+1
    task automatic send(input logic [7:0] d, input logic [7:0] w, input logic [1:0] m,
                        input bit si, input bit sw, input bit last);
        bit seen;
        bit done;
        in_valid = 1'b1;
        in_data  = d;
        weight   = w;
        mode     = m;
        s_in     = si;
        s_weight = sw;
        in_last  = last;
        done     = 1'b0;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            seen = in_ready;
            @(posedge clk);
            #1;
            if (seen) done = 1'b1;
            else out_ready = 1'b1;
        end
        in_valid = 1'b0;
        chk("accept", done, 1'b1);
        if (done) model_beat(d, w, m, si, sw, last);
    endtask

    task automatic check_results(input string tag);
        out_ready = 1'b1;
        for (int t = 0; t < 200 && got_psum.size() < exp_psum.size(); t++) begin
            @(posedge clk);
        end
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_count"}, got_psum.size(), exp_psum.size());
        while (got_psum.size() > 0 && exp_psum.size() > 0) begin
            last_psum = got_psum.pop_front();
            last_sat  = got_sat.pop_front();
            chk({tag, "_psum"}, last_psum, exp_psum.pop_front());
            chk({tag, "_sat"}, last_sat, exp_sat.pop_front());
        end
        got_psum.delete();
        got_sat.delete();
        exp_psum.delete();
        exp_sat.delete();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        weight    = '0;
        mode      = 2'b00;
        s_in      = 1'b0;
        s_weight  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        m_acc     = 0;
        m_sat     = 0;
        m_in_vec  = 0;
        last_psum = '0;
        last_sat  = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_psum", out_psum, 24'd0);
        chk("rst_out_sat", out_sat, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b1);

        // signed 1x, latency: valid two edges after accept
        send(8'hFF, 8'h02, 2'b00, 1, 1, 1);
        @(posedge clk);
        #1;
        chk("lat_edge1", out_valid, 1'b0);
        @(posedge clk);
        #1;
        chk("lat_edge2", out_valid, 1'b1);
        chk("lat_psum", out_psum, 24'hFFFFFE);
        check_results("neg2");

        // 2-lane unsigned, 4-lane signed
        send(8'h23, 8'h45, 2'b01, 0, 0, 1);
        check_results("mode2x");
        chk("mode2x_val", last_psum, 24'd23);
        send(8'hFF, 8'h55, 2'b10, 1, 1, 1);
        check_results("mode4x");
        chk("mode4x_val", last_psum, 24'hFFFFFC);

        // 4-beat vector, then a fresh vector from 0
        for (int i = 0; i < 4; i++) send(8'd10, 8'd10, 2'b00, 0, 0, i == 3);
        check_results("vec400");
        chk("vec400_val", last_psum, 24'd400);
        chk("vec400_sat", last_sat, 1'b0);
        send(8'd1, 8'd1, 2'b00, 0, 0, 1);
        check_results("restart");
        chk("restart_val", last_psum, 24'd1);

        // positive saturation, then sticky flag cleared on next vector
        for (int i = 0; i < 130; i++) send(8'hFF, 8'hFF, 2'b00, 0, 0, i == 129);
        check_results("satpos");
        chk("satpos_val", last_psum, 24'h7FFFFF);
        chk("satpos_flag", last_sat, 1'b1);
        send(8'd2, 8'd3, 2'b00, 0, 0, 1);
        check_results("postsat");
        chk("postsat_flag", last_sat, 1'b0);

        // downstream stall with a beat waiting
        out_ready = 1'b0;
        send(8'd7, 8'd6, 2'b00, 0, 0, 1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 8'd5;
        weight   = 8'd5;
        mode     = 2'b00;
        s_in     = 1'b0;
        s_weight = 1'b0;
        in_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("stall_in_ready", in_ready, 1'b0);
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_psum", out_psum, 24'd42);
        end
        out_ready = 1'b1;
        send(8'd5, 8'd5, 2'b00, 0, 0, 1);
        send(8'h34, 8'h12, 2'b01, 0, 1, 0);
        send(8'h9C, 8'h71, 2'b10, 1, 0, 1);
        send(8'd9, 8'd9, 2'b11, 0, 0, 1);
        send(8'h80, 8'h7F, 2'b00, 1, 1, 1);
        check_results("stall");

        // reset mid-vector drops the partial sum
        send(8'd1, 8'd1, 2'b00, 0, 0, 0);
        send(8'd2, 8'd2, 2'b00, 0, 0, 0);
        rst = 1'b1;
        #2;
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_psum", out_psum, 24'd0);
        chk("midrst_sat", out_sat, 1'b0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        m_in_vec = 0;
        @(posedge clk);
        #1;
        chk("midrst_ready", in_ready, 1'b1);
        send(8'd3, 8'd3, 2'b00, 0, 0, 1);
        check_results("midrst");
        chk("midrst_val", last_psum, 24'd9);

        // randomized vectors with bubbles and random backpressure
        for (int v = 0; v < 40; v++) begin
            int nb;
            nb = $urandom_range(1, 6);
            for (int b = 0; b < nb; b++) begin
                out_ready = ($urandom_range(0, 3) != 0);
                send(8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), b == nb - 1);
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        check_results("rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fusion_mac.md
FUSION_MAC -- requirements
Module: fusion_mac

Interface
REQ-001 Parameter W, default 8, operand width in bits; SHALL be a multiple of 4 and >= 4.
REQ-002 Parameter ACC_W, default 24, signed accumulator/result width; SHALL be >= 2*W+2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  beat offered.
REQ-006 in_ready  output  1  beat accepted when in_valid && in_ready at a rising edge.
REQ-007 in_data  input  W  activation operand.
REQ-008 weight  input  W  weight operand.
REQ-009 s_in  input  1  1 = in_data lanes signed, 0 = unsigned.
REQ-010 s_weight  input  1  1 = weight lanes signed, 0 = unsigned.
REQ-011 mode  input  2  fusion mode per beat: 00 = 1 lane of W; 01 = 2 lanes of W/2; 10 = 4 lanes of W/4; 11 = treated as 00.
REQ-012 in_last  input  1  marks final beat of a dot-product vector.
REQ-013 out_valid  output  1  result available.
REQ-014 out_ready  input  1  result consumed when out_valid && out_ready at a rising edge.
REQ-015 out_psum  output  ACC_W  signed vector result.
REQ-016 out_sat  output  1  result was clamped during this vector.

Function
REQ-017 Lane i uses bits [(i+1)*L-1 : i*L] of in_data and of weight, L = lane width for the mode.
REQ-018 Each lane product is 2L bits, signed if either operand is signed (each operand sign- or zero-extended per its flag), then extended to ACC_W.
REQ-019 Beat sum = sum of all lane products for that beat, exact in ACC_W.
REQ-020 Pipeline: stage 1 registers accepted operands/flags/mode/last; stage 2 registers beat sum with valid and last; stage 3 accumulates.
REQ-021 First beat after reset or after a last beat SHALL start the accumulator from 0; later beats add to it.
REQ-022 Accumulation SHALL saturate to +2^(ACC_W-1)-1 / -2^(ACC_W-1); any clamp sets a sticky saturation flag cleared at vector start.
REQ-023 When the last beat reaches stage 3, out_psum and out_sat SHALL load and out_valid SHALL rise; latency: last beat accepted at edge k -> out_valid high after edge k+2.
REQ-024 stall = out_valid && !out_ready; when stall, every pipeline and accumulator register SHALL hold and in_ready SHALL be 0; otherwise in_ready = 1.
REQ-025 out_valid SHALL fall after a handshake edge unless a new last beat completes at that same edge, in which case it stays high with new data.
REQ-026 out_psum and out_sat SHALL remain stable while out_valid && !out_ready.
REQ-027 Mode and sign flags MAY change every beat; each beat uses its own captured values.
REQ-028 Beats with in_valid low SHALL insert bubbles that do not alter the accumulator.

Reset
REQ-029 rst SHALL asynchronously clear all stage valids, accumulator, saturation flag, out_valid, out_psum, out_sat to 0; in_ready reads 1 one cycle after release.
REQ-030 rst mid-vector SHALL discard the partial sum; the next accepted beat starts a new vector.

Structure
REQ-031 Package fusion_pkg SHALL hold mode encodings (MODE_1X, MODE_2X, MODE_4X) and default W/ACC_W constants.
REQ-032 One sub-module fusion_lane_mult (parametrised lane width, per-operand sign flags, 2L-bit product) SHALL be instantiated per lane position.

Verification
REQ-033 mode 00, s_in=s_weight=1, in_data=8'hFF, weight=8'h02, in_last=1 -> out_psum=24'hFFFFFE, out_valid two edges after accept.
REQ-034 mode 01 unsigned, in_data=8'h23, weight=8'h45, last -> out_psum=23 (3*5+2*4); mode 10 signed, 8'hFF x 8'h55 -> out_psum=-4.
REQ-035 mode 00 unsigned, 4 beats 8'd10 x 8'd10, last on 4th -> out_psum=400, out_sat=0; next vector starts from 0.
REQ-036 mode 00 unsigned, 130 beats 8'hFF x 8'hFF -> out_psum=24'h7FFFFF, out_sat=1.
REQ-037 out_ready held 0 for 3 cycles with out_valid high -> in_ready=0, out_psum stable, no beat lost; back-to-back vectors resume correctly.
REQ-038 rst asserted after 2 of 4 beats -> outputs 0; new single-beat vector 3x3 -> out_psum=9.
